// File: rtl/uart_frame_streamer_if.sv
// Handshake bundle for uart_frame_streamer: the pixel stream from the read
// FIFO and the byte interface to the UART transmitter.
// master: the streamer side. slave: the FIFO/UART environment side.
interface uart_frame_streamer_if #(
  parameter int PIX_W = 10
);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             tx_done;

  modport master (
    input  pix_data, pix_valid, tx_busy, tx_done,
    output pix_ready, tx_data, tx_start
  );

  modport slave (
    output pix_data, pix_valid, tx_busy, tx_done,
    input  pix_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer: pulls pixels from a read FIFO (valid/ready) and
// serialises a frame onto a byte UART as a 5-byte header (sync, width, height)
// followed by BYTES_PER_PIX bytes per pixel, MSB byte first.
// Optional feature macro CHECKSUM_EN: appends an XOR checksum byte of all
// pixel bytes after the last pixel (state CSUM).
module uart_frame_streamer #(
  parameter int         WIDTH         = 640,
  parameter int         HEIGHT        = 480,
  parameter int         PIX_W         = 10,
  parameter int         BYTES_PER_PIX = 2,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  uart_frame_streamer_if.master bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [11:0]           h_cnt,
  output logic [11:0]           v_cnt,
  output logic [2:0]            state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
`ifdef CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd6;
`endif

  localparam logic [11:0] LP_WIDTH    = 12'(WIDTH);
  localparam logic [11:0] LP_HEIGHT   = 12'(HEIGHT);
  localparam logic [11:0] LP_HMAX     = 12'(WIDTH - 1);
  localparam logic [11:0] LP_VMAX     = 12'(HEIGHT - 1);
  localparam logic [1:0]  LP_LASTBYTE = 2'(BYTES_PER_PIX - 1);

  logic [2:0]  r_state;
  logic [2:0]  r_srcState;
  logic [2:0]  r_hdrIdx;
  logic [1:0]  r_byteIdx;
  logic [31:0] r_pix;
  logic [11:0] r_hCnt;
  logic [11:0] r_vCnt;
  logic        r_txStart;
`ifdef CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic [7:0]  w_hdrByte;
  logic [7:0]  w_pixByte;
  logic [7:0]  w_curByte;
  logic [2:0]  w_src;
  logic        w_lastPix;

  assign w_pixByte = r_pix[{r_byteIdx, 3'b000} +: 8];
  assign w_lastPix = (r_hCnt == LP_HMAX) && (r_vCnt == LP_VMAX);

  // Header byte for the current header index: sync, width hi/lo, height hi/lo.
  always_comb begin
    w_hdrByte = 8'h00;
    case (r_hdrIdx)
      3'd0:    w_hdrByte = SYNC_BYTE;
      3'd1:    w_hdrByte = {4'h0, LP_WIDTH[11:8]};
      3'd2:    w_hdrByte = LP_WIDTH[7:0];
      3'd3:    w_hdrByte = {4'h0, LP_HEIGHT[11:8]};
      3'd4:    w_hdrByte = LP_HEIGHT[7:0];
      default: w_hdrByte = 8'h00;
    endcase
  end

  // Byte on tx_data: chosen by the issuing state, held through WAIT_TX.
  always_comb begin
    w_src = r_state;
    if (r_state == S_WAIT_TX) w_src = r_srcState;
    w_curByte = 8'h00;
    case (w_src)
      S_HDR:   w_curByte = w_hdrByte;
      S_SEND:  w_curByte = w_pixByte;
`ifdef CHECKSUM_EN
      S_CSUM:  w_curByte = r_csum;
`endif
      default: w_curByte = 8'h00;
    endcase
  end

  // Frame sequencer: header, pixel fetch/send loop, optional checksum, done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_srcState <= S_IDLE;
      r_hdrIdx   <= 3'd0;
      r_byteIdx  <= 2'd0;
      r_pix      <= 32'h0;
      r_hCnt     <= 12'd0;
      r_vCnt     <= 12'd0;
      r_txStart  <= 1'b0;
`ifdef CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_txStart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_hCnt    <= 12'd0;
          r_vCnt    <= 12'd0;
          r_hdrIdx  <= 3'd0;
          r_byteIdx <= 2'd0;
`ifdef CHECKSUM_EN
          r_csum    <= 8'h00;
`endif
          if (en) r_state <= S_HDR;
        end
        S_HDR, S_SEND: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (!bus.tx_busy) begin
            r_txStart  <= 1'b1;
            r_srcState <= r_state;
            r_state    <= S_WAIT_TX;
`ifdef CHECKSUM_EN
            if (r_state == S_SEND) r_csum <= r_csum ^ w_pixByte;
`endif
          end
        end
`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (!bus.tx_busy) begin
            r_txStart  <= 1'b1;
            r_srcState <= S_CSUM;
            r_state    <= S_WAIT_TX;
          end
        end
`endif
        S_FETCH: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (bus.pix_valid) begin
            r_pix     <= 32'(bus.pix_data[PIX_W-1:0]);
            r_byteIdx <= LP_LASTBYTE;
            r_state   <= S_SEND;
          end
        end
        S_WAIT_TX: begin
          if (bus.tx_done) begin
            if (!en) begin
              r_state <= S_IDLE;
            end else begin
              case (r_srcState)
                S_HDR: begin
                  if (r_hdrIdx == 3'd4) begin
                    r_state <= S_FETCH;
                  end else begin
                    r_hdrIdx <= r_hdrIdx + 3'd1;
                    r_state  <= S_HDR;
                  end
                end
                S_SEND: begin
                  if (r_byteIdx != 2'd0) begin
                    r_byteIdx <= r_byteIdx - 2'd1;
                    r_state   <= S_SEND;
                  end else if (w_lastPix) begin
`ifdef CHECKSUM_EN
                    r_state <= S_CSUM;
`else
                    r_state <= S_DONE;
`endif
                  end else begin
                    if (r_hCnt == LP_HMAX) begin
                      r_hCnt <= 12'd0;
                      r_vCnt <= r_vCnt + 12'd1;
                    end else begin
                      r_hCnt <= r_hCnt + 12'd1;
                    end
                    r_state <= S_FETCH;
                  end
                end
`ifdef CHECKSUM_EN
                S_CSUM:  r_state <= S_DONE;
`endif
                default: r_state <= S_IDLE;
              endcase
            end
          end
        end
        S_DONE: begin
          if (!en) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready = (r_state == S_FETCH);
  assign bus.tx_data   = w_curByte;
  assign bus.tx_start  = r_txStart;
  assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign frame_done    = (r_state == S_DONE);
  assign h_cnt         = r_hCnt;
  assign v_cnt         = r_vCnt;
  assign state         = r_state;

endmodule

// File: tb/tb_uart_frame_streamer.sv
// Directed bench for uart_frame_streamer on a 2x2 frame of 10-bit pixels sent
// as 2 bytes each. A UART model answers every tx_start with tx_done four
// cycles later and records the bytes; a FIFO model serves queued pixels.
module tb_uart_frame_streamer;

  localparam int WIDTH  = 2;
  localparam int HEIGHT = 2;
  localparam int PIX_W  = 10;
  localparam int BPP    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        busy;
  logic        frameDone;
  logic [11:0] hCnt;
  logic [11:0] vCnt;
  logic [2:0]  state;

  uart_frame_streamer_if #(.PIX_W(PIX_W)) bus ();

  uart_frame_streamer #(
    .WIDTH(WIDTH),
    .HEIGHT(HEIGHT),
    .PIX_W(PIX_W),
    .BYTES_PER_PIX(BPP),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .bus(bus),
    .busy(busy),
    .frame_done(frameDone),
    .h_cnt(hCnt),
    .v_cnt(vCnt),
    .state(state)
  );

  always #5 clk = ~clk;

  logic [7:0]       sentQ[$];
  logic [PIX_W-1:0] pixQ[$];
  int               startCount = 0;
  int               startWhileBusy = 0;
  int               uartCnt = 0;
  logic             uartBusy = 1'b0;
  logic             uartDone = 1'b0;
  logic             forceBusy = 1'b0;

  assign bus.tx_busy = uartBusy | forceBusy;
  assign bus.tx_done = uartDone;

  // UART and FIFO models, updated on the falling edge away from DUT sampling.
  always @(negedge clk) begin
    uartDone = 1'b0;
    if (rst) begin
      uartBusy = 1'b0;
      uartCnt  = 0;
    end else if (bus.tx_start) begin
      if (bus.tx_busy) startWhileBusy++;
      startCount++;
      sentQ.push_back(bus.tx_data);
      uartBusy = 1'b1;
      uartCnt  = 4;
    end else if (uartBusy) begin
      uartCnt--;
      if (uartCnt == 0) begin
        uartBusy = 1'b0;
        uartDone = 1'b1;
      end
    end
    bus.pix_valid = (pixQ.size() != 0);
    bus.pix_data  = (pixQ.size() != 0) ? pixQ[0] : '0;
  end

  // FIFO pop on an accepted handshake.
  always @(posedge clk) begin
    if (bus.pix_valid && bus.pix_ready && pixQ.size() != 0) void'(pixQ.pop_front());
  end

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic enV);
    rst = rstV;
    en  = enV;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitState(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, {29'h0, state}, {29'h0, s});
  endtask

  function automatic logic [31:0] byteAt(input int k);
    if (k < sentQ.size()) return {24'h0, sentQ[k]};
    return 32'hDEAD;
  endfunction

  task automatic loadFrame();
    logic [PIX_W-1:0] pixVec[4];
    pixVec[0] = 10'h3FF;
    pixVec[1] = 10'h001;
    pixVec[2] = 10'h155;
    pixVec[3] = 10'h2AA;
    foreach (pixVec[i]) pixQ.push_back(pixVec[i]);
  endtask

  logic [7:0] expB[14];
  int         nExp;
  int         base;
  int         base2;
  int         s0;
  int         cnt;
  int         n;
  logic [7:0] d0;
  logic [11:0] h0;
  logic [11:0] v0;

  initial begin
    expB[0]  = 8'hA5; expB[1]  = 8'h00; expB[2]  = 8'h02; expB[3]  = 8'h00;
    expB[4]  = 8'h02; expB[5]  = 8'h03; expB[6]  = 8'hFF; expB[7]  = 8'h00;
    expB[8]  = 8'h01; expB[9]  = 8'h01; expB[10] = 8'h55; expB[11] = 8'h02;
    expB[12] = 8'hAA; expB[13] = 8'h00;
    nExp = 13;
`ifdef CHECKSUM_EN
    for (int i = 5; i < 13; i++) expB[13] = expB[13] ^ expB[i];
    nExp = 14;
`endif

    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("rst_state", {29'h0, state}, 32'd0);
    checkOutput("rst_tx_start", {31'h0, bus.tx_start}, 32'd0);
    checkOutput("rst_pix_ready", {31'h0, bus.pix_ready}, 32'd0);
    checkOutput("rst_tx_data", {24'h0, bus.tx_data}, 32'd0);
    checkOutput("rst_busy", {31'h0, busy}, 32'd0);
    checkOutput("rst_frame_done", {31'h0, frameDone}, 32'd0);
    checkOutput("rst_counters", {8'h0, hCnt, vCnt}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    tick();

    $display("[TB] basic frame");
    base = sentQ.size();
    loadFrame();
    applyStimulus(1'b0, 1'b1);
    waitState(3'd5, 2000, "t1_done_state");
    checkOutput("t1_byte_count", sentQ.size() - base, nExp);
    for (int i = 0; i < nExp; i++)
      checkOutput($sformatf("t1_byte%0d", i), byteAt(base + i), {24'h0, expB[i]});
    checkOutput("t1_frame_done", {31'h0, frameDone}, 32'd1);
    checkOutput("t1_busy", {31'h0, busy}, 32'd0);
    checkOutput("t1_last_counters", {8'h0, hCnt, vCnt}, {8'h0, 12'd1, 12'd1});
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("t1_back_idle", {29'h0, state}, 32'd0);
    tick();
    checkOutput("t1_idle_counters", {8'h0, hCnt, vCnt}, 32'd0);

    $display("[TB] busy gating and fifo stall");
    base = sentQ.size();
    pixQ.push_back(10'h3FF);
    applyStimulus(1'b0, 1'b1);
    waitState(3'd3, 500, "t2_reach_send");
    forceBusy = 1'b1;
    s0  = startCount;
    d0  = bus.tx_data;
    cnt = 0;
    repeat (20) begin
      tick();
      if (bus.tx_data !== d0 || state !== 3'd3) cnt++;
    end
    checkOutput("t2_no_start", startCount - s0, 0);
    checkOutput("t2_data_stable", cnt, 0);
    checkOutput("t2_data_value", {24'h0, d0}, 32'h03);
    forceBusy = 1'b0;
    repeat (3) tick();
    checkOutput("t2_one_start", startCount - s0, 1);
    checkOutput("t2_sent_byte", byteAt(base + 5), 32'h03);

    waitState(3'd2, 200, "t3_reach_fetch");
    h0  = hCnt;
    v0  = vCnt;
    s0  = startCount;
    cnt = 0;
    checkOutput("t3_counters_after_pix0", {8'h0, h0, v0}, {8'h0, 12'd1, 12'd0});
    repeat (50) begin
      tick();
      if (bus.pix_ready !== 1'b1 || hCnt !== h0 || vCnt !== v0 || state !== 3'd2) cnt++;
    end
    checkOutput("t3_stall_held", cnt, 0);
    checkOutput("t3_stall_no_start", startCount - s0, 0);
    pixQ.push_back(10'h001);
    pixQ.push_back(10'h155);
    pixQ.push_back(10'h2AA);
    waitState(3'd5, 2000, "t3_done_state");
    checkOutput("t3_byte_count", sentQ.size() - base, nExp);
    checkOutput("t3_byte10", byteAt(base + 10), 32'h55);
    checkOutput("t3_byte12", byteAt(base + 12), 32'hAA);

    $display("[TB] abort in WAIT_TX");
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    base = sentQ.size();
    loadFrame();
    applyStimulus(1'b0, 1'b1);
    n = 0;
    while (!(sentQ.size() == base + 9 && state === 3'd4) && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("t4_reach_byte9", sentQ.size() - base, 9);
    checkOutput("t4_byte8", byteAt(base + 8), 32'h01);
    checkOutput("t4_h_before", {20'h0, hCnt}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    s0 = startCount;
    tick();
    checkOutput("t4_hold_wait_tx", {29'h0, state}, 32'd4);
    waitState(3'd0, 20, "t4_idle_after_done");
    tick();
    checkOutput("t4_counters_cleared", {8'h0, hCnt, vCnt}, 32'd0);
    repeat (20) tick();
    checkOutput("t4_no_more_start", startCount - s0, 0);
    pixQ.delete();

    $display("[TB] reset mid-frame");
    base = sentQ.size();
    loadFrame();
    applyStimulus(1'b0, 1'b1);
    waitState(3'd3, 500, "t5_reach_send");
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("t5_state", {29'h0, state}, 32'd0);
    checkOutput("t5_tx_start", {31'h0, bus.tx_start}, 32'd0);
    checkOutput("t5_pix_ready", {31'h0, bus.pix_ready}, 32'd0);
    checkOutput("t5_header_only", sentQ.size() - base, 5);
    applyStimulus(1'b0, 1'b1);
    base2 = sentQ.size();
    n = 0;
    while (sentQ.size() <= base2 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t5_restart_sync", byteAt(base2), 32'hA5);
    applyStimulus(1'b0, 1'b0);
    repeat (10) tick();
    checkOutput("start_while_busy", startWhileBusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
